// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_arb_pkg                                                  |
// | Description : Shared types and widths for the memory-port arbiter.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Requester IDs double as the address-mux select values.
  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter_if                                          |
// | Description : Requester, response and memory-side signals of the arbiter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              lsu_req;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_we;
  logic [DATA_W-1:0] lsu_wdata;
  logic              if_gnt;
  logic              lsu_gnt;
  logic              if_rsp_valid;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              addr_sel;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, lsu_req, lsu_addr, lsu_we, lsu_wdata, mem_ready, mem_rdata,
    output if_gnt, lsu_gnt, if_rsp_valid, lsu_rsp_valid, rsp_rdata, rsp_err,
           addr_sel, mem_valid, mem_addr, mem_we, mem_wdata, busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, lsu_req, lsu_addr, lsu_we, lsu_wdata, mem_ready, mem_rdata,
    input  if_gnt, lsu_gnt, if_rsp_valid, lsu_rsp_valid, rsp_rdata, rsp_err,
           addr_sel, mem_valid, mem_addr, mem_we, mem_wdata, busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_arb_pick                                                 |
// | Description : Combinational winner select, fixed LSU priority or RR.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic    if_req,
  input  logic    lsu_req,
  input  req_id_e last_id,
  output logic    win_valid,
  output req_id_e win_id
);

  always_comb begin
    win_valid = if_req | lsu_req;
    win_id    = REQ_IF;
    if (if_req && lsu_req) begin
      // Round-robin favours whoever was not granted last.
      if (LSU_PRIO || (last_id == REQ_IF)) begin
        win_id = REQ_LSU;
      end
    end else if (lsu_req) begin
      win_id = REQ_LSU;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                             |
// | Description : Shares one memory port between IF and LSU, one transaction   |
// |               at a time. Optional timeout: define MEM_ARB_TIMEOUT_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit LSU_PRIO       = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e        r_state;
  req_id_e           r_last;
  logic              r_if_gnt;
  logic              r_lsu_gnt;
  logic              r_if_rsp_valid;
  logic              r_lsu_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_addr_sel;
  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_win_valid;
  req_id_e           w_win_id;
  logic              w_done;
  logic [DATA_W-1:0] w_fin_rdata;

  mem_arb_pick #(
    .LSU_PRIO (LSU_PRIO)
  ) u_pick (
    .if_req    (bus.if_req),
    .lsu_req   (bus.lsu_req),
    .last_id   (r_last),
    .win_valid (w_win_valid),
    .win_id    (w_win_id)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  // Holds (BUSY cycle index - 1); the last value marks the final allowed BUSY cycle.
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_rsp_err;
  logic               w_fin_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end
  end

  // A real completion on the expiry edge takes precedence over the timeout.
  assign w_done      = bus.mem_ready || (r_tmo_cnt == c_TMO_LAST);
  assign w_fin_rdata = bus.mem_ready ? bus.mem_rdata : '0;
  assign w_fin_err   = !bus.mem_ready;
  assign bus.rsp_err = r_rsp_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_done       = bus.mem_ready;
  assign w_fin_rdata  = bus.mem_rdata;
  assign bus.rsp_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_last          <= REQ_IF;
      r_if_gnt        <= 1'b0;
      r_lsu_gnt       <= 1'b0;
      r_if_rsp_valid  <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_rsp_rdata     <= '0;
      r_addr_sel      <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_we        <= 1'b0;
      r_mem_wdata     <= '0;
      r_busy          <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_rsp_err       <= 1'b0;
`endif
    end else begin
      r_if_gnt        <= 1'b0;
      r_lsu_gnt       <= 1'b0;
      r_if_rsp_valid  <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_state     <= BUSY;
            r_last      <= w_win_id;
            r_addr_sel  <= w_win_id;
            r_mem_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_if_gnt    <= (w_win_id == REQ_IF);
            r_lsu_gnt   <= (w_win_id == REQ_LSU);
            if (w_win_id == REQ_LSU) begin
              r_mem_addr  <= bus.lsu_addr;
              r_mem_we    <= bus.lsu_we;
              r_mem_wdata <= bus.lsu_wdata;
            end else begin
              r_mem_addr  <= bus.if_addr;
              r_mem_we    <= 1'b0;
              r_mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (w_done) begin
            r_state         <= IDLE;
            r_mem_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_rsp_rdata     <= w_fin_rdata;
            r_if_rsp_valid  <= (r_last == REQ_IF);
            r_lsu_rsp_valid <= (r_last == REQ_LSU);
`ifdef MEM_ARB_TIMEOUT_EN
            r_rsp_err       <= w_fin_err;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt        = r_if_gnt;
  assign bus.lsu_gnt       = r_lsu_gnt;
  assign bus.if_rsp_valid  = r_if_rsp_valid;
  assign bus.lsu_rsp_valid = r_lsu_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.addr_sel      = r_addr_sel;
  assign bus.mem_valid     = r_mem_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.busy          = r_busy;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between instruction fetch (IF) and the load/store unit (LSU).
- Arbitrates requests and sequences one transaction at a time.
- Drives the select of the 32-bit 2:1 address mux (0 = IF address, 1 = LSU address) and routes the response back to the winning requester.
- Sits between the fetch/LSU stages and the memory interface. It is the first multi-cycle control block in the core.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without mem_ready before an error response. Used only with MEM_ARB_TIMEOUT_EN.
- LSU_PRIO, 1: 1 = LSU always wins on contention; 0 = round-robin.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF request; held until if_gnt
- if_addr  in  32  IF address
- lsu_req  in  1  LSU request; held until lsu_gnt
- lsu_addr  in  32  LSU address
- lsu_we  in  1  LSU write enable
- lsu_wdata  in  32  LSU write data
- if_gnt  out  1  one-cycle accept pulse to IF
- lsu_gnt  out  1  one-cycle accept pulse to LSU
- if_rsp_valid  out  1  one-cycle response pulse to IF
- lsu_rsp_valid  out  1  one-cycle response pulse to LSU
- rsp_rdata  out  32  response data, valid with either rsp_valid
- rsp_err  out  1  timeout error, valid with either rsp_valid
- addr_sel  out  1  address-mux select, registered
- mem_valid  out  1  memory request valid
- mem_addr  out  32  latched request address
- mem_we  out  1  latched write enable (always 0 for IF)
- mem_wdata  out  32  latched write data
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  32  memory read data
- busy  out  1  transaction outstanding

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Every output is registered.
- Reset values: all outputs 0, state IDLE, round-robin pointer last = IF (so LSU wins the first contention).
- States: IDLE and BUSY.
- IDLE, at a clock edge where any req is high:
  - Pick the winner.
  - Next cycle: assert the winner's gnt for exactly 1 cycle, mem_valid=1, busy=1.
  - addr_sel, mem_addr, mem_we and mem_wdata are captured from the winner. IF forces mem_we=0 and mem_wdata=0.
  - Go to BUSY.
- BUSY:
  - mem_valid, addr_sel and all latched mem_* fields are held stable.
  - On an edge with mem_ready=1: clear mem_valid and busy, pulse the winner's rsp_valid for 1 cycle with rsp_rdata=mem_rdata and rsp_err=0, return to IDLE.
  - mem_ready is ignored in IDLE.
- Latency: req sampled at edge N → gnt and mem_valid in cycle N+1. With mem_ready in N+1, rsp_valid is in N+2. A pending request is sampled at edge N+2, giving the next mem_valid in N+3 (one bubble).
- Contention:
  - LSU_PRIO=1: LSU wins.
  - LSU_PRIO=0: the requester not granted last wins. The pointer updates on every grant, contended or not.
- A requester that drops req before gnt is not granted. No error is raised.
- A req asserted during BUSY is held off until IDLE.
- rsp_rdata and rsp_err hold their last values between pulses.
- Reset mid-transaction: aborts immediately. No rsp_valid is issued and all outputs go to reset values.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0, it takes effect at that edge: mem_valid=0, the winner's rsp_valid pulses with rsp_err=1 and rsp_rdata=0, return to IDLE.
  - If mem_ready=1 on the same edge the timeout would fire, the normal response wins.
- MEM_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely. rsp_err is tied 0 and the port remains.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1
  - requester IDs: REQ_IF=1'b0, REQ_LSU=1'b1 (these equal the addr_sel values)
  - ADDR_W=32, DATA_W=32
- Sub-module mem_arb_pick: combinational winner select. Inputs are if_req, lsu_req, the last-granted ID and LSU_PRIO; outputs are win_valid and win_id.

Test Plan:
- Single IF request: if_req=1, if_addr=0x0000_0040, mem_ready=1 one cycle after mem_valid → if_gnt pulse, addr_sel=0, mem_addr=0x40, mem_we=0, if_rsp_valid with rsp_rdata=mem_rdata=0x00A0_0093.
- LSU store, 3-cycle memory wait: lsu_addr=0x1000, lsu_we=1, lsu_wdata=0xDEAD_BEEF, mem_ready after 3 BUSY cycles → mem_* fields stable for all 3 cycles, lsu_rsp_valid once, rsp_err=0.
- Contention with LSU_PRIO=0: both req held for 4 transactions → grants alternate LSU, IF, LSU, IF. Repeat with LSU_PRIO=1 → LSU is granted every time while lsu_req stays high.
- Back-to-back: if_req held continuously with zero-wait memory → mem_valid pattern 1,0,1,0 and one if_rsp_valid per transaction.
- rst_n pulled low in BUSY cycle 2 → all outputs 0 asynchronously, no rsp_valid. After release, the next request starts cleanly.
- MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and mem_ready stuck 0 → rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 BUSY cycles. Second run with mem_ready=1 on cycle 16 → normal response, rsp_err=0.
